// File: rtl/pll_phase_comparator_if.sv
// Signal bundle between the phase comparator and its environment (VFO, reference, harness).
interface pll_phase_comparator_if #(
  parameter int CNT_W = 8
);
  logic                    Enable;
  logic                    RefIn;
  logic                    VfoIn;
  logic [1:0]              AdjustFreq;
  logic                    SampleCmd;
  logic signed [CNT_W:0]   PhaseErr;
  logic                    ErrValid;
  logic                    Locked;

  modport master (
    output Enable, RefIn, VfoIn,
    input  AdjustFreq, SampleCmd, PhaseErr, ErrValid, Locked
  );

  modport slave (
    input  Enable, RefIn, VfoIn,
    output AdjustFreq, SampleCmd, PhaseErr, ErrValid, Locked
  );
endinterface

// File: rtl/pll_phase_comparator.sv
// Phase comparator and loop controller: measures ref/VFO rising-edge skew in Clk
// cycles and drives the VFO frequency adjust code, phase error and lock status.
//
// state     | meaning
// IDLE      | startup delay, SampleCmd low
// WAIT_EDGE | waiting for the first edge of a pair
// REF_FIRST | ref edge seen, counting until VFO edge or timeout
// VFO_FIRST | VFO edge seen, counting until ref edge or timeout
// DECIDE    | error registered, ErrValid high for this cycle
// APPLY     | adjust code held, edges ignored
module pll_phase_comparator #(
  parameter int CNT_W      = 8,
  parameter int WINDOW     = 200,
  parameter int DEADBAND   = 2,
  parameter int ADJ_HOLD   = 4,
  parameter int LOCK_COUNT = 8,
  parameter int STARTUP    = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  pll_phase_comparator_if.slave pc
);

  typedef enum logic [2:0] {IDLE, WAIT_EDGE, REF_FIRST, VFO_FIRST, DECIDE, APPLY} state_t;

  localparam int TMR_W = 8;
  localparam int LCK_W = $clog2(LOCK_COUNT + 1);

  localparam logic [1:0] CODE_UP   = 2'b10;
  localparam logic [1:0] CODE_DOWN = 2'b00;
  localparam logic [1:0] CODE_HOLD = 2'b01;

  localparam logic [TMR_W-1:0]      STARTUP_LD = TMR_W'(STARTUP - 1);
  localparam logic [TMR_W-1:0]      HOLD_LD    = TMR_W'(ADJ_HOLD - 1);
  localparam logic [TMR_W-1:0]      TMR_ONE    = TMR_W'(1);
  localparam logic [CNT_W-1:0]      WIN_LAST   = CNT_W'(WINDOW - 1);
  localparam logic signed [CNT_W:0] WIN_S      = (CNT_W+1)'(WINDOW);
  localparam logic signed [CNT_W:0] DB_S       = (CNT_W+1)'(DEADBAND);
  localparam logic signed [CNT_W:0] ONE_S      = (CNT_W+1)'(1);
  localparam logic [LCK_W-1:0]      LOCK_MAX   = LCK_W'(LOCK_COUNT);

  logic [2:0]              refSync, vfoSync;
  logic                    refEdge, vfoEdge;
  state_t                  state;
  logic [CNT_W-1:0]        phaseCnt;
  logic [TMR_W-1:0]        timer;
  logic [LCK_W-1:0]        lockCnt, lockNext;
  logic                    decide, forceRaise, forceHold, inBand;
  logic signed [CNT_W:0]   decErr, cntPlus1;
  logic [1:0]              decAdj;

  // Two sync flops plus a history flop; both inputs see identical latency.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      refSync <= '0;
      vfoSync <= '0;
      refEdge <= 1'b0;
      vfoEdge <= 1'b0;
    end else begin
      refSync <= {refSync[1:0], pc.RefIn};
      vfoSync <= {vfoSync[1:0], pc.VfoIn};
      refEdge <= refSync[1] & ~refSync[2];
      vfoEdge <= vfoSync[1] & ~vfoSync[2];
    end
  end

  assign cntPlus1 = signed'({1'b0, phaseCnt}) + ONE_S;

  always_comb begin
    decide     = 1'b0;
    decErr     = '0;
    forceRaise = 1'b0;
    forceHold  = 1'b0;
    case (state)
      WAIT_EDGE: decide = refEdge && vfoEdge;
      REF_FIRST: begin
        if (vfoEdge) begin
          decide = 1'b1;
          decErr = cntPlus1;
        end else if (phaseCnt == WIN_LAST) begin
          decide     = 1'b1;
          decErr     = WIN_S;
          forceRaise = 1'b1;
        end
      end
      VFO_FIRST: begin
        if (refEdge) begin
          decide = 1'b1;
          decErr = -cntPlus1;
        end else if (phaseCnt == WIN_LAST) begin
          // Missing reference: report the error but do not steer the VFO.
          decide    = 1'b1;
          decErr    = -WIN_S;
          forceHold = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    inBand = !forceRaise && !forceHold && (decErr <= DB_S) && (decErr >= -DB_S);
    if (forceHold)                        decAdj = CODE_HOLD;
    else if (forceRaise || decErr > DB_S) decAdj = CODE_UP;
    else if (decErr < -DB_S)              decAdj = CODE_DOWN;
    else                                  decAdj = CODE_HOLD;
    if (!inBand)                  lockNext = '0;
    else if (lockCnt == LOCK_MAX) lockNext = lockCnt;
    else                          lockNext = lockCnt + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset || !pc.Enable) begin
      state         <= IDLE;
      phaseCnt      <= '0;
      timer         <= STARTUP_LD;
      lockCnt       <= '0;
      pc.AdjustFreq <= CODE_HOLD;
      pc.SampleCmd  <= 1'b0;
      pc.Locked     <= 1'b0;
      pc.ErrValid   <= 1'b0;
      if (Reset) pc.PhaseErr <= '0;
    end else begin
      pc.ErrValid <= 1'b0;
      if (decide) begin
        state         <= DECIDE;
        pc.PhaseErr   <= decErr;
        pc.ErrValid   <= 1'b1;
        pc.AdjustFreq <= decAdj;
        lockCnt       <= lockNext;
        pc.Locked     <= (lockNext == LOCK_MAX);
      end else begin
        case (state)
          IDLE: begin
            if (timer == '0) begin
              state        <= WAIT_EDGE;
              pc.SampleCmd <= 1'b1;
            end else begin
              timer <= timer - 1'b1;
            end
          end
          WAIT_EDGE: begin
            phaseCnt <= '0;
            if (refEdge)      state <= REF_FIRST;
            else if (vfoEdge) state <= VFO_FIRST;
          end
          REF_FIRST, VFO_FIRST: phaseCnt <= phaseCnt + 1'b1;
          DECIDE: begin
            state <= APPLY;
            timer <= HOLD_LD;
            if (HOLD_LD == '0) pc.AdjustFreq <= CODE_HOLD;
          end
          // Code drops to hold one cycle before leaving, so a new pair can
          // only be measured ADJ_HOLD+2 cycles after the previous decision.
          APPLY: begin
            if (timer == '0) begin
              state <= WAIT_EDGE;
            end else begin
              if (timer == TMR_ONE) pc.AdjustFreq <= CODE_HOLD;
              timer <= timer - 1'b1;
            end
          end
          default: begin
            state        <= IDLE;
            timer        <= STARTUP_LD;
            pc.SampleCmd <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_phase_comparator.sv
// Directed bench for pll_phase_comparator: startup, lag/lead/deadband, lock, timeouts, aborts.
module tb_pll_phase_comparator;

  logic Clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  pll_phase_comparator_if #(.CNT_W(8)) pcIf ();

  pll_phase_comparator dut (
    .Clk   (Clk),
    .Reset (Reset),
    .pc    (pcIf)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Enable/reset release at the current negedge; SampleCmd must stay low 4 cycles.
  task automatic releaseCheck(input string tag);
    Reset       = 1'b0;
    pcIf.Enable = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      chk($sformatf("%s.samp%0d", tag, i), pcIf.SampleCmd, (i == 4) ? 1 : 0);
      chk($sformatf("%s.adj%0d", tag, i), pcIf.AdjustFreq, 2'b01);
      @(negedge Clk);
    end
  endtask

  task automatic runPair(input int rOff, input int vOff, input int n);
    for (int i = 0; i < n; i++) begin
      pcIf.RefIn = (i >= rOff) && (i < rOff + 2);
      pcIf.VfoIn = (i >= vOff) && (i < vOff + 2);
      @(negedge Clk);
    end
    pcIf.RefIn = 1'b0;
    pcIf.VfoIn = 1'b0;
  endtask

  // s: negedge index of the second (or timed-out) detection; decision shows at s+4.
  task automatic pair(input int rOff, input int vOff, input int s, input int expErr,
                      input logic [1:0] expAdj, input logic expLock, input string tag);
    for (int i = 0; i <= s + 9; i++) begin
      if (i == s + 3) chk({tag, ".early"}, pcIf.ErrValid, 0);
      if (i == s + 4) begin
        chk({tag, ".valid"}, pcIf.ErrValid, 1);
        chk({tag, ".err"}, pcIf.PhaseErr, expErr);
        chk({tag, ".adj"}, pcIf.AdjustFreq, expAdj);
        chk({tag, ".lock"}, pcIf.Locked, expLock);
      end
      if (i == s + 5) chk({tag, ".pulse"}, pcIf.ErrValid, 0);
      if (i == s + 7) chk({tag, ".hold"}, pcIf.AdjustFreq, expAdj);
      if (i == s + 8) chk({tag, ".ret"}, pcIf.AdjustFreq, 2'b01);
      pcIf.RefIn = (i >= rOff) && (i < rOff + 2);
      pcIf.VfoIn = (i >= vOff) && (i < vOff + 2);
      @(negedge Clk);
    end
  endtask

  initial begin
    Reset       = 1'b1;
    pcIf.Enable = 1'b1;
    pcIf.RefIn  = 1'b0;
    pcIf.VfoIn  = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst.adj", pcIf.AdjustFreq, 2'b01);
    chk("rst.samp", pcIf.SampleCmd, 0);
    chk("rst.err", pcIf.PhaseErr, 0);
    chk("rst.valid", pcIf.ErrValid, 0);
    chk("rst.lock", pcIf.Locked, 0);
    releaseCheck("startup");

    pair(0, 6, 6, 6, 2'b10, 1'b0, "lag");
    for (int k = 1; k <= 8; k++) pair(0, 0, 0, 0, 2'b01, k == 8, $sformatf("simA%0d", k));
    pair(1000, 0, 200, -200, 2'b01, 1'b0, "vfoTimeout");
    for (int k = 1; k <= 8; k++) pair(0, 0, 0, 0, 2'b01, k == 8, $sformatf("simB%0d", k));
    pair(0, 7, 7, 7, 2'b10, 1'b0, "lockLoss");
    pair(5, 0, 5, -5, 2'b00, 1'b0, "lead");
    pair(0, 2, 2, 2, 2'b01, 1'b0, "deadband");
    pair(0, 1000, 200, 200, 2'b10, 1'b0, "refTimeout");
    for (int k = 1; k <= 8; k++) pair(0, 0, 0, 0, 2'b01, k == 8, $sformatf("simC%0d", k));

    // Enable drop while in REF_FIRST, loop locked beforehand
    runPair(0, 1000, 5);
    chk("abA.prelock", pcIf.Locked, 1);
    pcIf.Enable = 1'b0;
    @(negedge Clk);
    chk("abA.adj", pcIf.AdjustFreq, 2'b01);
    chk("abA.samp", pcIf.SampleCmd, 0);
    chk("abA.lock", pcIf.Locked, 0);
    chk("abA.err", pcIf.PhaseErr, 0);
    releaseCheck("abA");

    // Enable drop during APPLY keeps PhaseErr
    runPair(0, 6, 12);
    chk("abB.preadj", pcIf.AdjustFreq, 2'b10);
    pcIf.Enable = 1'b0;
    @(negedge Clk);
    chk("abB.adj", pcIf.AdjustFreq, 2'b01);
    chk("abB.samp", pcIf.SampleCmd, 0);
    chk("abB.lock", pcIf.Locked, 0);
    chk("abB.err", pcIf.PhaseErr, 6);
    releaseCheck("abB");

    // Reset pulse during APPLY clears PhaseErr
    runPair(0, 6, 12);
    chk("abC.preadj", pcIf.AdjustFreq, 2'b10);
    Reset = 1'b1;
    @(negedge Clk);
    chk("abC.adj", pcIf.AdjustFreq, 2'b01);
    chk("abC.samp", pcIf.SampleCmd, 0);
    chk("abC.err", pcIf.PhaseErr, 0);
    releaseCheck("abC");

    // Reset pulse during REF_FIRST
    pair(5, 0, 5, -5, 2'b00, 1'b0, "abD.lead");
    runPair(0, 1000, 5);
    chk("abD.presamp", pcIf.SampleCmd, 1);
    Reset = 1'b1;
    @(negedge Clk);
    chk("abD.adj", pcIf.AdjustFreq, 2'b01);
    chk("abD.samp", pcIf.SampleCmd, 0);
    chk("abD.lock", pcIf.Locked, 0);
    chk("abD.err", pcIf.PhaseErr, 0);
    releaseCheck("abD");

    pair(0, 3, 3, 3, 2'b10, 1'b0, "post");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_phase_comparator.md
# pll_phase_comparator

Synchronous phase comparator and loop controller closing the PLL loop around the VFO. It samples the reference stream and the VFO clock output on the system clock, measures the rising-edge phase error in system-clock cycles, and drives the VFO's `AdjustFreq` code and `SampleCmd` enable. It also reports signed phase error and a lock indication to the test harness.

## Interface
- `CNT_W`, 8: phase counter width. `PhaseErr` is `CNT_W+1` bits signed.
- `WINDOW`, 200: maximum cycles to wait for the second edge; must be < 2^CNT_W.
- `DEADBAND`, 2: `|error| <= DEADBAND` counts as in phase.
- `ADJ_HOLD`, 4: cycles a non-hold `AdjustFreq` code is driven.
- `LOCK_COUNT`, 8: consecutive in-deadband decisions needed to assert `Locked`.
- `STARTUP`, 4: cycles after reset or enable with `SampleCmd` low.

- `Clk` in 1: system sampling clock; all logic on the rising edge.
- `Reset` in 1: reset, synchronous, active-high.
- `Enable` in 1: loop enable. Low forces IDLE.
- `RefIn` in 1: reference clock or data transitions; asynchronous.
- `VfoIn` in 1: VFO `ClockOut`; asynchronous.
- `AdjustFreq` out 2: `2'b10` = raise frequency, `2'b00` = lower frequency, `2'b01` = hold.
- `SampleCmd` out 1: VFO run enable, held at level.
- `PhaseErr` out CNT_W+1: signed error from the last decision. Positive means the VFO lags.
- `ErrValid` out 1: one-cycle pulse when `PhaseErr` updates.
- `Locked` out 1: lock indication.

## Operation
- `RefIn` and `VfoIn` each pass through a 2-flop synchronizer, then a registered rising-edge detector.
- FSM states: IDLE, WAIT_EDGE, REF_FIRST, VFO_FIRST, DECIDE, APPLY.
- **IDLE**
  - Counts `STARTUP` cycles with `SampleCmd`=0, then goes to WAIT_EDGE.
  - `SampleCmd`=1 in every state except IDLE.
- **WAIT_EDGE**
  - Ref edge only: go to REF_FIRST with counter=0.
  - VFO edge only: go to VFO_FIRST with counter=0.
  - Both edges in the same cycle: error=0, go to DECIDE.
- **REF_FIRST / VFO_FIRST**
  - Counter increments by 1 each cycle.
  - The other edge arriving with counter=c gives error = c+1 (cycles between the two detections), signed `+` for REF_FIRST and `-` for VFO_FIRST. Go to DECIDE.
  - A repeat of the first edge in these states is ignored.
- **Timeout:** counter reaching `WINDOW` without the other edge.
  - In REF_FIRST: error = `+WINDOW`, marked out-of-band, so the VFO is treated as too slow.
  - In VFO_FIRST: error = `-WINDOW`, but the decision is forced to hold (missing reference) and the lock counter is cleared.
- **DECIDE** (one cycle)
  - Registers `PhaseErr` and pulses `ErrValid`.
  - `AdjustFreq` = `10` if error > `DEADBAND`, `00` if error < `-DEADBAND`, else `01`.
  - Go to APPLY.
- **APPLY**
  - Holds `AdjustFreq` for `ADJ_HOLD` cycles, then sets it to `01` and returns to WAIT_EDGE.
  - Edges detected during DECIDE and APPLY are discarded.
- **Lock counter**
  - In-deadband decision: increment, saturating at `LOCK_COUNT`.
  - Any other decision or any timeout: clear.
  - `Locked` = (counter == `LOCK_COUNT`).
- **`Enable` low or `Reset` high at any point**
  - Next state IDLE and all counters cleared.
  - `AdjustFreq`=01, `SampleCmd`=0, `Locked`=0, `ErrValid`=0.
  - `PhaseErr` is cleared only by `Reset`.

## Timing
- **Reset values:** `AdjustFreq`=2'b01, `SampleCmd`=0, `PhaseErr`=0, `ErrValid`=0, `Locked`=0.
- **Input latency:** pin to edge detect is 3 `Clk` cycles, equal for both inputs, so phase error is unbiased.
- **Second edge detected at cycle t:**
  - `PhaseErr`, `ErrValid` and `AdjustFreq` change at t+1.
  - `AdjustFreq` returns to 01 at t+1+`ADJ_HOLD`.
  - `Locked` updates at t+1.
- **`SampleCmd` rises** `STARTUP` cycles after `Reset` deasserts (with `Enable`=1), or after `Enable` rises.
- **Minimum decision period:** `ADJ_HOLD`+2 cycles.

## Test plan
- **Startup:** assert `Reset` 3 cycles with `Enable`=1, then release → `SampleCmd` stays 0 for 4 cycles and rises on cycle 5; `AdjustFreq`=01 throughout.
- **VFO lags:** ref edge, VFO edge 6 cycles later → `PhaseErr`=+6, `ErrValid` pulses once, `AdjustFreq`=10 for exactly 4 cycles, then 01.
- **VFO leads and deadband:**
  - VFO edge 5 cycles before ref → `PhaseErr`=-5, `AdjustFreq`=00.
  - VFO edge 2 cycles after ref → `PhaseErr`=+2, `AdjustFreq`=01.
- **Simultaneous edges and lock:** 8 consecutive edge pairs arriving in the same cycle → `PhaseErr`=0 each time and `Locked` rises on the 8th `ErrValid`. A 9th pair with +7 error → `Locked` falls with that `ErrValid`.
- **Timeouts:**
  - Ref edge with no VFO edge → after 200 cycles `PhaseErr`=+200, `AdjustFreq`=10.
  - VFO edge with no ref edge → `PhaseErr`=-200, `AdjustFreq`=01, lock counter cleared.
- **Mid-operation abort:** drop `Enable`, then separately pulse `Reset`, each during REF_FIRST and during APPLY → next cycle `AdjustFreq`=01, `SampleCmd`=0, `Locked`=0. The restart repeats the 4-cycle startup.
